alu_uart_ctrl: RTL

Sequencing controller that lets a UART host drive the combinational ALU. It collects three received bytes (operand A, operand B, opcode) and presents them to the ALU. It registers the result and returns a two-byte reply (result, status) through the UART transmitter handshake. It sits between the UART RX/TX blocks and the ALU in the board top level; the ALU is instantiated beside it, not inside it.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/timeout_counter.sv | 26 ++
 rtl/alu_uart_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, controller state encoding and opcode check.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC,
    S_SEND_RES, S_WAIT_RES, S_SEND_STAT, S_WAIT_STAT
  } ctrl_state_e;

  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte idle counter: runs while enabled, pulses expire on its last count.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // A zero limit disables expiry entirely.
  assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr || !en || expire) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// UART-to-ALU sequencer: gathers A, B, opcode bytes, then replies result and status.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OP_WIDTH       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_zero,
  output logic                  o_busy,
  output logic                  o_timeout
);

  ctrl_state_e state;
  logic err, zero, accept, expire, op_err;

  assign accept = i_rx_done && (state inside {S_WAIT_A, S_WAIT_B, S_WAIT_OP});
  assign op_err = (i_rx_data[DATA_WIDTH-1:OP_WIDTH] != '0) || !op_valid(i_rx_data[OP_WIDTH-1:0]);

  timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (state == S_WAIT_B || state == S_WAIT_OP),
    .expire (expire)
  );

  // The result byte is captured straight into o_tx_data so its start pulse
  // lands in the cycle after EXEC; o_tx_data doubles as the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      err        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        S_WAIT_A: if (i_rx_done) begin
          o_alu_a <= i_rx_data;
          state   <= S_WAIT_B;
        end
        S_WAIT_B: if (i_rx_done) begin
          o_alu_b <= i_rx_data;
          state   <= S_WAIT_OP;
        end else if (expire) begin
          o_timeout <= 1'b1;
          state     <= S_WAIT_A;
        end
        S_WAIT_OP: if (i_rx_done) begin
          o_alu_op <= i_rx_data[OP_WIDTH-1:0];
          err      <= op_err;
          o_busy   <= 1'b1;
          state    <= S_EXEC;
        end else if (expire) begin
          o_timeout <= 1'b1;
          state     <= S_WAIT_A;
        end
        S_EXEC: begin
          o_tx_data  <= i_alu_result;
          zero       <= i_alu_zero;
          o_tx_start <= 1'b1;
          state      <= S_SEND_RES;
        end
        S_SEND_RES: state <= S_WAIT_RES;
        S_WAIT_RES: if (i_tx_done) begin
          o_tx_data  <= {{(DATA_WIDTH-2){1'b0}}, err, zero};
          o_tx_start <= 1'b1;
          state      <= S_SEND_STAT;
        end
        S_SEND_STAT: state <= S_WAIT_STAT;
        S_WAIT_STAT: if (i_tx_done) begin
          o_busy <= 1'b0;
          state  <= S_WAIT_A;
        end
        default: state <= S_WAIT_A;
      endcase
    end
  end

endmodule
